// File: rtl/br_commit_queue_pkg.sv
// Shared entry type, sizing defaults and training-strobe polarity macros
// for the in-order branch commit queue.
`ifndef Enable_
`define Enable_ 1'b0
`endif
`ifndef Disable_
`define Disable_ 1'b1
`endif

package br_commit_queue_pkg;

    localparam int BrqDepthDef = 8;
    localparam int BrqAddrDef  = 32;
    localparam int BrqTagW     = $clog2(BrqDepthDef);

    // Direction bits are stored active-high (1 = taken).
    typedef struct packed {
        logic                  valid;
        logic                  resolved;
        logic                  jump;
        logic [BrqAddrDef-1:0] pc;
        logic                  pred_taken;
        logic [BrqAddrDef-1:0] pred_addr;
        logic                  act_taken;
        logic [BrqAddrDef-1:0] act_addr;
    } brq_entry_t;

endpackage

// File: rtl/br_commit_queue_miss_chk.sv
// Combinational commit/miss evaluation of one queue entry, producing the
// next values of the active-low BTB training strobes.
`ifndef Enable_
`define Enable_ 1'b0
`endif
`ifndef Disable_
`define Disable_ 1'b1
`endif

module brq_miss_chk
    import br_commit_queue_pkg::*;
(
    input  brq_entry_t            ent,
    input  logic                  en,
    output logic                  commit,
    output logic                  miss,
    output logic                  br_commit_,
    output logic                  br_taken_,
    output logic                  br_miss_,
    output logic                  jump_commit_,
    output logic                  jump_miss_,
    output logic [BrqAddrDef-1:0] com_pc,
    output logic [BrqAddrDef-1:0] com_tar
);

    logic br_miss;
    logic jump_miss;

    always_comb begin
        br_miss      = (ent.pred_taken != ent.act_taken) ||
                       (ent.act_taken && (ent.pred_addr != ent.act_addr));
        jump_miss    = !ent.pred_taken || (ent.pred_addr != ent.act_addr);
        commit       = en && ent.valid && ent.resolved;
        miss         = commit && (ent.jump ? jump_miss : br_miss);
        br_commit_   = `Disable_;
        br_taken_    = `Disable_;
        br_miss_     = `Disable_;
        jump_commit_ = `Disable_;
        jump_miss_   = `Disable_;
        com_pc       = ent.pc;
        com_tar      = ent.act_addr;
        if (commit) begin
            if (ent.jump) begin
                jump_commit_ = `Enable_;
                jump_miss_   = jump_miss ? `Enable_ : `Disable_;
            end else begin
                br_commit_   = `Enable_;
                br_taken_    = ent.act_taken ? `Enable_ : `Disable_;
                br_miss_     = br_miss ? `Enable_ : `Disable_;
            end
        end
    end

endmodule

// File: rtl/br_commit_queue.sv
// In-order branch resolution queue feeding BTB training strobes.
// Optional feature macro: BRQ_STAT_EN adds commit/miss statistics counters.
`ifndef Enable_
`define Enable_ 1'b0
`endif
`ifndef Disable_
`define Disable_ 1'b1
`endif

module br_commit_queue
    import br_commit_queue_pkg::*;
#(
    parameter  int ADDR  = BrqAddrDef,   // entry fields are BrqAddrDef wide
    parameter  int DEPTH = BrqDepthDef,
    localparam int TAG   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset_,
    input  logic            flush_,
    input  logic            alloc_,
    input  logic            alloc_jump_,
    input  logic [ADDR-1:0] alloc_pc,
    input  logic            alloc_pred_taken_,
    input  logic [ADDR-1:0] alloc_pred_addr,
    output logic [TAG-1:0]  alloc_tag,
    output logic            brq_full,
    input  logic            res_,
    input  logic [TAG-1:0]  res_tag,
    input  logic            res_taken_,
    input  logic [ADDR-1:0] res_addr,
    output logic            br_commit_,
    output logic            br_taken_,
    output logic            br_miss_,
    output logic            jump_commit_,
    output logic            jump_miss_,
    output logic [ADDR-1:0] com_addr,
    output logic [ADDR-1:0] com_tar_addr
`ifdef BRQ_STAT_EN
    ,
    output logic [31:0]     stat_commit,
    output logic [31:0]     stat_miss
`endif
);

    brq_entry_t      entries_q [DEPTH];
    brq_entry_t      entries_d [DEPTH];
    logic [TAG-1:0]  head_q, head_d;
    logic [TAG-1:0]  tail_q, tail_d;
    logic [TAG:0]    count_q, count_d;

    logic            br_commit_q, br_commit_d;
    logic            br_taken_q, br_taken_d;
    logic            br_miss_q, br_miss_d;
    logic            jump_commit_q, jump_commit_d;
    logic            jump_miss_q, jump_miss_d;
    logic [ADDR-1:0] com_addr_q, com_addr_d;
    logic [ADDR-1:0] com_tar_addr_q, com_tar_addr_d;

    logic            do_flush;
    logic            do_res;
    logic            do_alloc;
    logic            commit;
    logic            miss;
    logic            chk_br_commit_, chk_br_taken_, chk_br_miss_;
    logic            chk_jump_commit_, chk_jump_miss_;
    logic [ADDR-1:0] chk_pc, chk_tar;

    assign alloc_tag    = tail_q;
    assign brq_full     = (count_q == (TAG+1)'(DEPTH));
    assign br_commit_   = br_commit_q;
    assign br_taken_    = br_taken_q;
    assign br_miss_     = br_miss_q;
    assign jump_commit_ = jump_commit_q;
    assign jump_miss_   = jump_miss_q;
    assign com_addr     = com_addr_q;
    assign com_tar_addr = com_tar_addr_q;

    // A flush in the same cycle suppresses the head commit entirely.
    brq_miss_chk u_miss_chk (
        .ent          (entries_q[head_q]),
        .en           (flush_),
        .commit       (commit),
        .miss         (miss),
        .br_commit_   (chk_br_commit_),
        .br_taken_    (chk_br_taken_),
        .br_miss_     (chk_br_miss_),
        .jump_commit_ (chk_jump_commit_),
        .jump_miss_   (chk_jump_miss_),
        .com_pc       (chk_pc),
        .com_tar      (chk_tar)
    );

    always_comb begin
        entries_d      = entries_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        br_commit_d    = `Disable_;
        br_taken_d     = `Disable_;
        br_miss_d      = `Disable_;
        jump_commit_d  = `Disable_;
        jump_miss_d    = `Disable_;
        com_addr_d     = com_addr_q;
        com_tar_addr_d = com_tar_addr_q;
        do_flush       = !flush_;
        do_res         = !res_ && entries_q[res_tag].valid && !do_flush;
        do_alloc       = !alloc_ && !brq_full && !do_flush && !miss;

        if (do_flush) begin
            for (int i = 0; i < DEPTH; i++) entries_d[i].valid = 1'b0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_res) begin
                entries_d[res_tag].resolved  = 1'b1;
                entries_d[res_tag].act_taken = !res_taken_;
                entries_d[res_tag].act_addr  = res_addr;
            end
            // Pop is applied after resolve so a pop always wins on the head entry.
            if (commit) begin
                br_commit_d    = chk_br_commit_;
                br_taken_d     = chk_br_taken_;
                br_miss_d      = chk_br_miss_;
                jump_commit_d  = chk_jump_commit_;
                jump_miss_d    = chk_jump_miss_;
                com_addr_d     = chk_pc;
                com_tar_addr_d = chk_tar;
                entries_d[head_q].valid = 1'b0;
                head_d = head_q + TAG'(1);
            end
            if (miss) begin
                // Younger entries are wrong-path once the head mispredicts.
                for (int i = 0; i < DEPTH; i++) entries_d[i].valid = 1'b0;
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else begin
                if (do_alloc) begin
                    entries_d[tail_q].valid      = 1'b1;
                    entries_d[tail_q].resolved   = 1'b0;
                    entries_d[tail_q].jump       = !alloc_jump_;
                    entries_d[tail_q].pc         = alloc_pc;
                    entries_d[tail_q].pred_taken = !alloc_pred_taken_;
                    entries_d[tail_q].pred_addr  = alloc_pred_addr;
                    entries_d[tail_q].act_taken  = 1'b0;
                    entries_d[tail_q].act_addr   = '0;
                    tail_d = tail_q + TAG'(1);
                end
                count_d = count_q + (TAG+1)'(do_alloc) - (TAG+1)'(commit);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            br_commit_q    <= `Disable_;
            br_taken_q     <= `Disable_;
            br_miss_q      <= `Disable_;
            jump_commit_q  <= `Disable_;
            jump_miss_q    <= `Disable_;
            com_addr_q     <= '0;
            com_tar_addr_q <= '0;
        end else begin
            entries_q      <= entries_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            br_commit_q    <= br_commit_d;
            br_taken_q     <= br_taken_d;
            br_miss_q      <= br_miss_d;
            jump_commit_q  <= jump_commit_d;
            jump_miss_q    <= jump_miss_d;
            com_addr_q     <= com_addr_d;
            com_tar_addr_q <= com_tar_addr_d;
        end
    end

`ifdef BRQ_STAT_EN
    // Statistics survive flushes; only reset clears them.
    logic [31:0] stat_commit_q, stat_commit_d;
    logic [31:0] stat_miss_q, stat_miss_d;

    always_comb begin
        stat_commit_d = stat_commit_q + 32'(commit);
        stat_miss_d   = stat_miss_q + 32'(miss);
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            stat_commit_q <= '0;
            stat_miss_q   <= '0;
        end else begin
            stat_commit_q <= stat_commit_d;
            stat_miss_q   <= stat_miss_d;
        end
    end

    assign stat_commit = stat_commit_q;
    assign stat_miss   = stat_miss_q;
`endif

endmodule
